// File: rtl/qdec_step_gen_if.sv
// qdec_step_gen_if: encoder inputs, step/direction/error outputs of the quadrature front end.
// The index pair idx_in/idx_clr exists only when QDEC_INDEX_EN is defined.
interface qdec_step_gen_if;
    logic en;
    logic a_in;
    logic b_in;
    logic err_clr;
    logic step;
    logic up_down;
    logic err;
`ifdef QDEC_INDEX_EN
    logic idx_in;
    logic idx_clr;

    modport master (
        output en, a_in, b_in, err_clr, idx_in,
        input  step, up_down, err, idx_clr
    );
    modport slave (
        input  en, a_in, b_in, err_clr, idx_in,
        output step, up_down, err, idx_clr
    );
`else
    modport master (
        output en, a_in, b_in, err_clr,
        input  step, up_down, err
    );
    modport slave (
        input  en, a_in, b_in, err_clr,
        output step, up_down, err
    );
`endif
endinterface : qdec_step_gen_if

// File: rtl/qdec_step_gen.sv
// qdec_step_gen: synchronise, glitch-filter and Gray-decode encoder A/B into step/up_down/err.
// Optional index channel (idx_in -> idx_clr) is built when QDEC_INDEX_EN is defined.
module qdec_step_gen #(
    parameter int FILT_CNT = 2,
    parameter int MODE     = 4
) (
    input  logic           clk,
    input  logic           rstn,
    qdec_step_gen_if.slave bus
);

`ifdef QDEC_INDEX_EN
    localparam int NCH  = 3;
    localparam int CH_I = 2;
`else
    localparam int NCH  = 2;
`endif
    localparam int CW = 4;
    localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CNT - 1);

    if (FILT_CNT < 1 || FILT_CNT > 15) begin : g_bad_filt_cnt
        $error("qdec_step_gen: FILT_CNT must be in 1..15");
    end
    if (MODE != 1 && MODE != 2 && MODE != 4) begin : g_bad_mode
        $error("qdec_step_gen: MODE must be 1, 2 or 4");
    end

    typedef enum logic {
        S_INIT,
        S_TRACK
    } state_t;

    // Forward Gray order on {A,B}: 00 -> 10 -> 11 -> 01 -> 00.
    function automatic logic is_fwd(input logic [1:0] p, input logic [1:0] c);
        case ({p, c})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: is_fwd = 1'b1;
            default:                                is_fwd = 1'b0;
        endcase
    endfunction

    function automatic logic mode_qual(input logic [1:0] p, input logic [1:0] c);
        case (MODE)
            1:       mode_qual = ({p, c} == 4'b00_10) || ({p, c} == 4'b10_00);
            2:       mode_qual = (p[1] != c[1]);
            4:       mode_qual = 1'b1;
            default: mode_qual = 1'b0;
        endcase
    endfunction

    state_t         state;
    state_t         state_nxt;
    logic           init_cnt;
    logic           init_cnt_nxt;
    logic           init_load;
    logic [NCH-1:0] raw_in;
    logic [NCH-1:0] s1;
    logic [NCH-1:0] s2;
    logic [NCH-1:0] filt;
    logic [CW-1:0]  cnt [NCH];
    logic [1:0]     cur_ab;
    logic [1:0]     prev_ab;
    logic [1:0]     prev_ab_nxt;
    logic [1:0]     ab_diff;
    logic           step_q;
    logic           step_nxt;
    logic           up_down_q;
    logic           up_down_nxt;
    logic           err_q;
    logic           err_nxt;

`ifdef QDEC_INDEX_EN
    logic prev_idx;
    logic prev_idx_nxt;
    logic idx_clr_q;
    logic idx_clr_nxt;

    assign raw_in      = {bus.idx_in, bus.a_in, bus.b_in};
    assign bus.idx_clr = idx_clr_q;
`else
    assign raw_in = {bus.a_in, bus.b_in};
`endif

    // NOTE: synchroniser flops carry no reset so s2 already holds the live input level when S_INIT samples it.
    always_ff @(posedge clk) begin
        s1 <= raw_in;
        s2 <= s1;
    end

    // A channel is accepted only after FILT_CNT consecutive cycles disagreeing with filt.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            filt <= '0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else if (state == S_INIT) begin
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
            if (init_load) filt <= s2;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (s2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == FILT_LAST) begin
                    filt[i] <= s2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign cur_ab  = filt[1:0];
    assign ab_diff = prev_ab ^ cur_ab;

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        init_load    = 1'b0;
        prev_ab_nxt  = prev_ab;
        step_nxt     = 1'b0;
        up_down_nxt  = up_down_q;
        err_nxt      = err_q & ~bus.err_clr;
`ifdef QDEC_INDEX_EN
        prev_idx_nxt = prev_idx;
        idx_clr_nxt  = 1'b0;
`endif
        case (state)
            S_INIT: begin
                init_cnt_nxt = 1'b1;
                if (init_cnt) begin
                    init_load   = 1'b1;
                    prev_ab_nxt = s2[1:0];
`ifdef QDEC_INDEX_EN
                    prev_idx_nxt = s2[CH_I];
`endif
                    state_nxt   = S_TRACK;
                end
            end
            S_TRACK: begin
                // prev_ab follows filt even when disabled, so re-enabling never replays old motion.
                prev_ab_nxt = cur_ab;
                if (ab_diff == 2'b11) begin
                    err_nxt = 1'b1;
                end else if (ab_diff != 2'b00 && bus.en && mode_qual(prev_ab, cur_ab)) begin
                    step_nxt    = 1'b1;
                    up_down_nxt = is_fwd(prev_ab, cur_ab);
                end
`ifdef QDEC_INDEX_EN
                prev_idx_nxt = filt[CH_I];
                idx_clr_nxt  = bus.en && filt[CH_I] && !prev_idx && (cur_ab == 2'b00);
`endif
            end
            default: state_nxt = S_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignment so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= S_INIT;
            init_cnt  <= 1'b0;
            prev_ab   <= 2'b00;
            step_q    <= 1'b0;
            up_down_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            prev_ab   <= prev_ab_nxt;
            step_q    <= step_nxt;
            up_down_q <= up_down_nxt;
            err_q     <= err_nxt;
        end
    end

`ifdef QDEC_INDEX_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev_idx  <= 1'b0;
            idx_clr_q <= 1'b0;
        end else begin
            prev_idx  <= prev_idx_nxt;
            idx_clr_q <= idx_clr_nxt;
        end
    end
`endif

    assign bus.step    = step_q;
    assign bus.up_down = up_down_q;
    assign bus.err     = err_q;

endmodule : qdec_step_gen

// File: tb/tb_qdec_step_gen.sv
// tb_qdec_step_gen: directed vectors for an X4 and an X1 instance of qdec_step_gen (FILT_CNT=2).
// Step latency is measured from the first posedge that samples a changed input.
module tb_qdec_step_gen;
    logic clk = 1'b0;
    logic rstn;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    int n_step = 0, n_up = 0, n_dn = 0, step_cyc = 0;
    int x1_step = 0, x1_up = 0, x1_dn = 0, x1_cyc = 0;
`ifdef QDEC_INDEX_EN
    int n_idx = 0, idx_cyc = 0;
`endif

    qdec_step_gen_if bus ();
    qdec_step_gen_if bus1 ();

    assign bus1.en      = bus.en;
    assign bus1.a_in    = bus.a_in;
    assign bus1.b_in    = bus.b_in;
    assign bus1.err_clr = bus.err_clr;
`ifdef QDEC_INDEX_EN
    assign bus1.idx_in  = bus.idx_in;
`endif

    qdec_step_gen #(.FILT_CNT(2), .MODE(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    qdec_step_gen #(.FILT_CNT(2), .MODE(1)) dut_x1 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus1.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.step === 1'b1) begin
            n_step++;
            if (bus.up_down === 1'b1) n_up++;
            else n_dn++;
            step_cyc = cyc;
        end
        if (bus1.step === 1'b1) begin
            x1_step++;
            if (bus1.up_down === 1'b1) x1_up++;
            else x1_dn++;
            x1_cyc = cyc;
        end
`ifdef QDEC_INDEX_EN
        if (bus.idx_clr === 1'b1) begin
            n_idx++;
            idx_cyc = cyc;
        end
`endif
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drive_ab(input logic a, input logic b, output int k);
        @(negedge clk);
        bus.a_in = a;
        bus.b_in = b;
        k = cyc + 1;
    endtask

    task automatic step_to(input logic a, input logic b, input logic exp_up, input string tag);
        int k;
        int c0;
        c0 = n_step;
        drive_ab(a, b, k);
        hold(10);
        check({tag, " count"}, n_step - c0, 1);
        check({tag, " latency"}, step_cyc - k, 4);
        check({tag, " up_down"}, bus.up_down, exp_up);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, cycle %0d, expected below 20000", cyc);
        $fatal(1);
    end

    initial begin
        int k;
        int k0;
        int c0;
        int c1;
        int c2;

        rstn        = 1'b0;
        bus.en      = 1'b1;
        bus.a_in    = 1'b0;
        bus.b_in    = 1'b0;
        bus.err_clr = 1'b0;
`ifdef QDEC_INDEX_EN
        bus.idx_in  = 1'b0;
`endif
        hold(3);
        check("reset step", bus.step, 0);
        check("reset up_down", bus.up_down, 1);
        check("reset err", bus.err, 0);
        rstn = 1'b1;
        hold(5);
        check("post-init no step", n_step, 0);

        // T1 forward sequence
        step_to(1'b1, 1'b0, 1'b1, "T1 00->10");
        step_to(1'b1, 1'b1, 1'b1, "T1 10->11");
        step_to(1'b0, 1'b1, 1'b1, "T1 11->01");
        step_to(1'b0, 1'b0, 1'b1, "T1 01->00");
        check("T1 err", bus.err, 0);

        // T2 reverse sequence
        c0 = n_dn;
        step_to(1'b0, 1'b1, 1'b0, "T2 00->01");
        step_to(1'b1, 1'b1, 1'b0, "T2 01->11");
        step_to(1'b1, 1'b0, 1'b0, "T2 11->10");
        step_to(1'b0, 1'b0, 1'b0, "T2 10->00");
        check("T2 down steps", n_dn - c0, 4);

        // T3 glitch rejection, then a 2-cycle pulse (rise steps up, fall steps down)
        c0 = n_step;
        @(negedge clk); bus.a_in = 1'b1;
        @(negedge clk); bus.a_in = 1'b0;
        hold(10);
        check("T3 1-cycle pulse steps", n_step - c0, 0);
        check("T3 1-cycle pulse err", bus.err, 0);
        c1 = n_up;
        c2 = n_dn;
        @(negedge clk); bus.a_in = 1'b1;
        hold(2);
        bus.a_in = 1'b0;
        hold(12);
        check("T3 2-cycle pulse up steps", n_up - c1, 1);
        check("T3 2-cycle pulse return steps", n_dn - c2, 1);
        check("T3 reversal up_down", bus.up_down, 0);

        // T4 double-bit error, sticky, clear vs coincident new error
        c0 = n_step;
        drive_ab(1'b1, 1'b1, k);
        wait_cyc(k + 3);
        check("T4 err before k+4", bus.err, 0);
        wait_cyc(k + 4);
        check("T4 err at k+4", bus.err, 1);
        hold(10);
        check("T4 err held", bus.err, 1);
        check("T4 no step", n_step - c0, 0);
        check("T4 up_down unchanged", bus.up_down, 0);
        step_to(1'b0, 1'b1, 1'b1, "T4 resume 11->01");
        step_to(1'b0, 1'b0, 1'b1, "T4 resume 01->00");
        check("T4 err sticky", bus.err, 1);
        c0 = n_step;
        drive_ab(1'b1, 1'b1, k);
        wait_cyc(k + 3);
        bus.err_clr = 1'b1;
        wait_cyc(k + 4);
        bus.err_clr = 1'b0;
        check("T4 clr vs new err", bus.err, 1);
        hold(5);
        check("T4 second err no step", n_step - c0, 0);
        @(negedge clk); bus.err_clr = 1'b1;
        @(negedge clk); bus.err_clr = 1'b0;
        check("T4 err cleared", bus.err, 0);
        hold(3);
        check("T4 err stays clear", bus.err, 0);

        step_to(1'b0, 1'b1, 1'b1, "T4 walk 11->01");
        step_to(1'b0, 1'b0, 1'b1, "T4 walk 01->00");
        step_to(1'b0, 1'b1, 1'b0, "T5 prep 00->01");

        // T5 disabled motion never replays on re-enable
        @(negedge clk); bus.en = 1'b0;
        c0 = n_step;
        drive_ab(1'b0, 1'b0, k); hold(10);
        drive_ab(1'b1, 1'b0, k); hold(10);
        drive_ab(1'b1, 1'b1, k); hold(10);
        check("T5 disabled steps", n_step - c0, 0);
        check("T5 disabled up_down held", bus.up_down, 0);
        @(negedge clk); bus.en = 1'b1;
        hold(10);
        check("T5 re-enable steps", n_step - c0, 0);
        step_to(1'b0, 1'b1, 1'b1, "T5 first enabled 11->01");

        // T6 X1 instance: one step per full cycle
        step_to(1'b0, 1'b0, 1'b1, "T6 prep 01->00");
        c0 = x1_step;
        c1 = x1_up;
        c2 = n_step;
        drive_ab(1'b1, 1'b0, k0); hold(10);
        drive_ab(1'b1, 1'b1, k);  hold(10);
        drive_ab(1'b0, 1'b1, k);  hold(10);
        drive_ab(1'b0, 1'b0, k);  hold(10);
        check("T6 X1 fwd steps", x1_step - c0, 1);
        check("T6 X1 fwd up steps", x1_up - c1, 1);
        check("T6 X1 latency", x1_cyc - k0, 4);
        check("T6 X4 fwd steps", n_step - c2, 4);
        c0 = x1_step;
        c1 = x1_dn;
        drive_ab(1'b0, 1'b1, k); hold(10);
        drive_ab(1'b1, 1'b1, k); hold(10);
        drive_ab(1'b1, 1'b0, k); hold(10);
        drive_ab(1'b0, 1'b0, k); hold(10);
        check("T6 X1 rev steps", x1_step - c0, 1);
        check("T6 X1 rev down steps", x1_dn - c1, 1);
        check("T6 X1 up_down", bus1.up_down, 0);

`ifdef QDEC_INDEX_EN
        c0 = n_idx;
        @(negedge clk); bus.idx_in = 1'b1; k = cyc + 1;
        hold(6);
        bus.idx_in = 1'b0;
        hold(10);
        check("IDX pulse count", n_idx - c0, 1);
        check("IDX latency", idx_cyc - k, 4);
`endif

        // Reset mid-operation with err set and inputs at 11
        drive_ab(1'b1, 1'b1, k);
        hold(10);
        check("RST err before reset", bus.err, 1);
        @(negedge clk); rstn = 1'b0;
        hold(2);
        check("RST step", bus.step, 0);
        check("RST up_down", bus.up_down, 1);
        check("RST err", bus.err, 0);
        check("RST X1 err", bus1.err, 0);
        c0 = n_step;
        c1 = x1_step;
        rstn = 1'b1;
        hold(15);
        check("RST no spurious step", n_step - c0, 0);
        check("RST X1 no spurious step", x1_step - c1, 0);
        check("RST no spurious err", bus.err, 0);
        check("RST up_down after init", bus.up_down, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule : tb_qdec_step_gen
